// File: rtl/jk_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_pulse_pkg
// Description : Shared types and constants for the JK pulse generator:
//               debounce FSM state encoding and default qualification length.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_pulse_pkg;

    // Five states do not fit in two bits, so the encoding is three bits wide.
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_PRESS   = 3'd1,
        PRESSED      = 3'd2,
        HELD         = 3'd3,
        WAIT_RELEASE = 3'd4
    } btn_state_e;

    // 10 ms at 100 MHz.
    localparam int DEFAULT_DEBOUNCE = 1_000_000;

    // The only state that emits a pulse; keeping the decode here makes the
    // Moore output obvious wherever a channel is built.
    function automatic logic is_pulse_state(input btn_state_e s);
        return (s == PRESSED);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : jk_pulse_gen_if
// Description : Button inputs and J/K pulse outputs of the JK pulse generator.
//               The master side drives the buttons and observes J/K; the
//               slave side is the pulse generator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface jk_pulse_gen_if;

    logic btn_set;   // raw, asynchronous, active-high: requests J
    logic btn_clr;   // raw, asynchronous, active-high: requests K
    logic J;         // one-cycle set pulse
    logic K;         // one-cycle clear pulse

    modport master (
        output btn_set,
        output btn_clr,
        input  J,
        input  K
    );

    modport slave (
        input  btn_set,
        input  btn_clr,
        output J,
        output K
    );

endinterface
`default_nettype wire

// File: rtl/jk_pulse_gen_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_pulse
// Description : One button channel: 2-flop synchronizer, qualification
//               counter and a press/release FSM that emits a single
//               one-cycle pulse per accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_pulse
    import jk_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic btn,
    output logic      pulse
);

    // Derived only; wide enough to hold DEBOUNCE_CYCLES-1.
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    btn_state_e       state_q;
    btn_state_e       state_d;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
        end
    end

    // State and qualification counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and counter. The counter is compared before it increments
    // and is zero on every state change, so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (!s2_q) begin
                    // Bounce: start qualification over.
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                // Single pulse cycle, whatever the button does now.
                state_d = HELD;
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (s2_q) begin
                    // Release bounce: still held, no new pulse.
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decoded from registered state: glitch-free.
    always_comb begin
        pulse = is_pulse_state(state_q);
    end

endmodule
`default_nettype wire

// File: rtl/jk_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : jk_pulse_gen
// Description : Debounced single-cycle J/K pulse generator. Two independent
//               button channels; when both pulse in the same cycle the set
//               pulse wins and the clear pulse is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_pulse_gen
    import jk_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  wire logic     clk,
    input  wire logic     rst,
    jk_pulse_gen_if.slave bus
);

    logic p_set;
    logic p_clr;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_set (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_set),
        .pulse (p_set)
    );

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_clr),
        .pulse (p_clr)
    );

    // Set priority: a coincident clear pulse is discarded, not deferred.
    always_comb begin
        bus.J = p_set;
        bus.K = p_clr & ~p_set;
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_pulse_gen
// Description : Self-checking bench for jk_pulse_gen with DEBOUNCE_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_pulse_gen;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    jk_pulse_gen_if bus ();

    jk_pulse_gen #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: run-length view of the delayed button level.
    // A press is accepted after D+1 consecutive high samples while armed;
    // the sample right after acceptance is ignored; re-arming needs D+1
    // consecutive low samples. Samples reach the decision two edges late.
    // ------------------------------------------------------------------
    bit h1 [2];
    bit h2 [2];
    bit armed [2] = '{1'b1, 1'b1};
    bit skip  [2];
    int run   [2];
    bit mp    [2];
    bit mJ, mK;

    task automatic chan(input int c, input bit x);
        mp[c] = 1'b0;
        if (skip[c]) begin
            skip[c] = 1'b0;
            run[c]  = 0;
        end else if (armed[c]) begin
            run[c] = x ? run[c] + 1 : 0;
            if (run[c] == D + 1) begin
                mp[c]    = 1'b1;
                armed[c] = 1'b0;
                skip[c]  = 1'b1;
                run[c]   = 0;
            end
        end else begin
            run[c] = x ? 0 : run[c] + 1;
            if (run[c] == D + 1) begin
                armed[c] = 1'b1;
                run[c]   = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        bit xs, xc;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                h1[c] = 0; h2[c] = 0; armed[c] = 1; skip[c] = 0; run[c] = 0; mp[c] = 0;
            end
        end else begin
            xs = h2[0];
            xc = h2[1];
            h2[0] = h1[0]; h1[0] = bus.btn_set;
            h2[1] = h1[1]; h1[1] = bus.btn_clr;
            chan(0, xs);
            chan(1, xc);
        end
        mJ = mp[0];
        mK = mp[1] & ~mp[0];
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic step(input logic r, input logic s, input logic c);
        @(negedge clk);
        rst         = r;
        bus.btn_set = s;
        bus.btn_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_jk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: JK got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string name);
        chk_jk(name, {bus.J, bus.K}, {mJ, mK});
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic  r;
        logic  s;
        logic  c;
        logic  ej;
        logic  ek;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic c,
                       input logic ej, input logic ek, input string name);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.ej = ej; v.ek = ek; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        logic [8:0] bpat;
        int         npulse;
        logic       prev_k;
        int         wide;
        logic       rs, rc;

        bus.btn_set = 1'b0;
        bus.btn_clr = 1'b0;

        // Reset state
        step(1, 0, 0);
        step(1, 0, 0);
        chk_jk("reset", {bus.J, bus.K}, 2'b00);

        // Clean press: pulse only after edge 7, never again while held.
        add(1, 0, 0, 0, 0, "clean_rst");
        for (int k = 1; k <= 24; k++)
            add(0, k <= 20, 0, k == 7, 0, "clean");

        // Bounce on clear: first attempt fails, pulse after edge 10.
        bpat = 9'b1_1111_1011;
        add(1, 0, 0, 0, 0, "bounce_rst");
        for (int k = 1; k <= 16; k++)
            add(0, 0, (k > 9) ? 1'b1 : bpat[k-1], 0, k == 10, "bounce");
        add(0, 0, 0, 0, 0, "bounce_tail");

        // Simultaneous press: set wins, clear dropped.
        add(1, 0, 0, 0, 0, "simul_rst");
        for (int k = 1; k <= 16; k++)
            add(0, 1, 1, k == 7, 0, "simul");

        // Reset at edge 5 with the button still held: one pulse after edge 12.
        add(1, 0, 0, 0, 0, "midrst_rst");
        for (int k = 1; k <= 20; k++)
            add(k == 5, 1, 0, k == 12, 0, "midrst");
        add(1, 0, 0, 0, 0, "table_end");

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].s, vecs[i].c);
            chk_jk(vecs[i].name, {bus.J, bus.K}, {vecs[i].ej, vecs[i].ek});
        end

        // Release bounce: exactly one J pulse for the whole sequence.
        step(1, 0, 0);
        npulse = 0;
        for (int k = 1; k <= 35; k++) begin
            step(0, !(k > 10 && k <= 12), 0);
            chk_model("relbounce");
            if (bus.J) npulse++;
        end
        chk_int("relbounce_pulses", npulse, 1);

        // Repeat presses on clear: three single-cycle K pulses.
        step(1, 0, 0);
        npulse = 0;
        wide   = 0;
        prev_k = 1'b0;
        for (int k = 0; k < 70; k++) begin
            step(0, 0, (k < 60) && ((k % 20) < 10));
            chk_model("repeat");
            if (bus.K && !prev_k) npulse++;
            if (bus.K && prev_k) wide++;
            prev_k = bus.K;
        end
        chk_int("repeat_pulses", npulse, 3);
        chk_int("repeat_wide", wide, 0);

        // Randomized: slowly toggling buttons, occasional reset.
        step(1, 0, 0);
        rs = 1'b0;
        rc = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 7) == 0) rs = ~rs;
            if ($urandom_range(0, 7) == 0) rc = ~rc;
            step($urandom_range(0, 399) == 0, rs, rc);
            chk_model("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
